// File: rtl/set_mode_ctrl_pkg.sv
// Shared types for the front-panel set-mode sequencer: FSM states (whose codes double as
// the display field_id), counter group select and field index constants.
package set_mode_ctrl_pkg;

    // State codes equal the field_id shown on the display (0 = none).
    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_SEC   = 3'd1,
        ST_MIN   = 3'd2,
        ST_HOUR  = 3'd3,
        ST_DAY   = 3'd4,
        ST_MONTH = 3'd5,
        ST_YEAR  = 3'd6
    } state_e;

    localparam logic SEL_TIME = 1'b0;
    localparam logic SEL_DATE = 1'b1;

    localparam logic [1:0] FLD_SEC   = 2'd0;
    localparam logic [1:0] FLD_MIN   = 2'd1;
    localparam logic [1:0] FLD_HOUR  = 2'd2;
    localparam logic [1:0] FLD_DAY   = 2'd0;
    localparam logic [1:0] FLD_MONTH = 2'd1;
    localparam logic [1:0] FLD_YEAR  = 2'd2;

    function automatic logic state_sel(input state_e s);
        return (s >= ST_DAY) ? SEL_DATE : SEL_TIME;
    endfunction

    function automatic logic [1:0] state_fld(input state_e s);
        logic [1:0] f;
        f = FLD_SEC;
        case (s)
            ST_MIN:   f = FLD_MIN;
            ST_HOUR:  f = FLD_HOUR;
            ST_DAY:   f = FLD_DAY;
            ST_MONTH: f = FLD_MONTH;
            ST_YEAR:  f = FLD_YEAR;
            default:  f = FLD_SEC;
        endcase
        return f;
    endfunction

    function automatic state_e next_field(input state_e s);
        state_e n;
        n = ST_RUN;
        case (s)
            ST_SEC:   n = ST_MIN;
            ST_MIN:   n = ST_HOUR;
            ST_HOUR:  n = ST_DAY;
            ST_DAY:   n = ST_MONTH;
            ST_MONTH: n = ST_YEAR;
            ST_YEAR:  n = ST_SEC;
            default:  n = ST_RUN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/set_mode_ctrl_debounce.sv
// One button: 2-FF synchroniser, consecutive-sample debounce counter, and a one-cycle
// press pulse on the debounced falling (pressed) edge. level_o is high while held.
module set_mode_ctrl_debounce #(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q, deb_q, press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            // Any sample that agrees with the current debounced level restarts the count.
            if (sync2_q == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                cnt_q   <= '0;
                deb_q   <= sync2_q;
                press_q <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = ~deb_q;
    assign press_o = press_q;

endmodule

// File: rtl/set_mode_ctrl.sv
// Front-panel sequencer: debounced buttons drive the RUN/SET field FSM and single-tick
// inc/dec steps; counter-side outputs change only on upd_tick. Option: AUTOREPEAT_EN.
module set_mode_ctrl
    import set_mode_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES    = 1000,
    parameter int TIMEOUT_TICKS = 30,
    parameter int RPT_DLY_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       upd_tick,
    input  logic       mode_btn_n,
    input  logic       next_btn_n,
    input  logic       up_btn_n,
    input  logic       down_btn_n,
    output logic       set_mode,
    output logic       sel,
    output logic [1:0] set_select,
    output logic       inc_btn,
    output logic       dec_btn,
    output logic [2:0] field_id
);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic mode_p, next_p, up_p, down_p;
    logic mode_lvl, next_lvl, up_lvl, down_lvl;

    set_mode_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk(clk), .rst_n(rst_n), .btn_n_i(mode_btn_n), .level_o(mode_lvl), .press_o(mode_p));
    set_mode_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .clk(clk), .rst_n(rst_n), .btn_n_i(next_btn_n), .level_o(next_lvl), .press_o(next_p));
    set_mode_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk(clk), .rst_n(rst_n), .btn_n_i(up_btn_n), .level_o(up_lvl), .press_o(up_p));
    set_mode_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
        .clk(clk), .rst_n(rst_n), .btn_n_i(down_btn_n), .level_o(down_lvl), .press_o(down_p));

    logic unused_lvl;
    assign unused_lvl = ^{mode_lvl, next_lvl, up_lvl, down_lvl, RPT_DLY_TICKS[0]};

    state_e        state_q;
    logic          set_mode_q, sel_q, inc_q, dec_q, pend_inc_q, pend_dec_q;
    logic [1:0]    set_select_q;
    logic [TW-1:0] to_cnt_q;

    logic in_set, any_press, step_active, fld_match, issue, timeout;
    assign in_set      = (state_q != ST_RUN);
    assign any_press   = mode_p | next_p | up_p | down_p;
    assign step_active = ~inc_q | ~dec_q;
    assign fld_match   = (sel_q == state_sel(state_q)) && (set_select_q == state_fld(state_q));
    // A step is only issued once the counter already sees the field it is meant for.
    assign issue   = upd_tick & ~step_active & (pend_inc_q | pend_dec_q)
                   & set_mode_q & in_set & fld_match;
    assign timeout = upd_tick & in_set & ~any_press & (to_cnt_q == TW'(TIMEOUT_TICKS - 1));

`ifdef AUTOREPEAT_EN
    localparam int RW = $clog2(RPT_DLY_TICKS + 1);
    logic [RW-1:0] rpt_cnt_q;
    logic          hold_up, hold_dn, rearm;
    assign hold_up = up_lvl & ~down_lvl;
    assign hold_dn = down_lvl & ~up_lvl;
    assign rearm   = upd_tick & in_set & (hold_up | hold_dn)
                   & ((int'(rpt_cnt_q) + 1) >= RPT_DLY_TICKS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q <= '0;
        end else if (up_p || down_p || !(hold_up || hold_dn)) begin
            rpt_cnt_q <= '0;
        end else if (upd_tick && (int'(rpt_cnt_q) < RPT_DLY_TICKS)) begin
            rpt_cnt_q <= rpt_cnt_q + RW'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            set_mode_q   <= 1'b0;
            sel_q        <= SEL_TIME;
            set_select_q <= FLD_SEC;
            inc_q        <= 1'b1;
            dec_q        <= 1'b1;
            pend_inc_q   <= 1'b0;
            pend_dec_q   <= 1'b0;
            to_cnt_q     <= '0;
        end else begin
            if (upd_tick) begin
                if (issue) begin
                    inc_q      <= ~pend_inc_q;
                    dec_q      <= ~pend_dec_q;
                    pend_inc_q <= 1'b0;
                    pend_dec_q <= 1'b0;
                end else begin
                    inc_q        <= 1'b1;
                    dec_q        <= 1'b1;
                    set_mode_q   <= in_set;
                    sel_q        <= state_sel(state_q);
                    set_select_q <= state_fld(state_q);
                end
            end
`ifdef AUTOREPEAT_EN
            if (rearm) begin
                pend_inc_q <= hold_up;
                pend_dec_q <= hold_dn;
            end
`endif
            if (in_set && up_p && !down_p) begin
                pend_inc_q <= 1'b1;
                pend_dec_q <= 1'b0;
            end else if (in_set && down_p && !up_p) begin
                pend_inc_q <= 1'b0;
                pend_dec_q <= 1'b1;
            end
            if (mode_p) begin
                state_q    <= in_set ? ST_RUN : ST_SEC;
                pend_inc_q <= 1'b0;
                pend_dec_q <= 1'b0;
            end else if (next_p && in_set) begin
                state_q    <= next_field(state_q);
                pend_inc_q <= 1'b0;
                pend_dec_q <= 1'b0;
            end else if (timeout) begin
                state_q    <= ST_RUN;
                pend_inc_q <= 1'b0;
                pend_dec_q <= 1'b0;
            end
            if (!in_set || any_press || timeout) begin
                to_cnt_q <= '0;
            end else if (upd_tick) begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end
        end
    end

    assign set_mode   = set_mode_q;
    assign sel        = sel_q;
    assign set_select = set_select_q;
    assign inc_btn    = inc_q;
    assign dec_btn    = dec_q;
    assign field_id   = state_q;

endmodule

// File: tb/tb_set_mode_ctrl.sv
// Bench for set_mode_ctrl: directed vector table, hand-written corner sequences and
// random button/tick traffic checked against an event-level model of the panel.
module tb_set_mode_ctrl;
    localparam int DEB = 8;
    localparam int TO  = 30;
    localparam int OP_TICK = 0, OP_MODE = 1, OP_NEXT = 2, OP_UP = 3, OP_DOWN = 4, OP_BOTH = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       upd_tick = 1'b0;
    logic       mode_btn_n = 1'b1, next_btn_n = 1'b1, up_btn_n = 1'b1, down_btn_n = 1'b1;
    logic       set_mode, sel, inc_btn, dec_btn;
    logic [1:0] set_select;
    logic [2:0] field_id;

    int n_tests = 0;
    int n_fail  = 0;

    set_mode_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT_TICKS(TO), .RPT_DLY_TICKS(2)) dut (
        .clk(clk), .rst_n(rst_n), .upd_tick(upd_tick),
        .mode_btn_n(mode_btn_n), .next_btn_n(next_btn_n),
        .up_btn_n(up_btn_n), .down_btn_n(down_btn_n),
        .set_mode(set_mode), .sel(sel), .set_select(set_select),
        .inc_btn(inc_btn), .dec_btn(dec_btn), .field_id(field_id));

    always #5 clk = ~clk;

    // Reference model: panel state at the level of whole presses and ticks.
    int   m_field, m_pend, m_idle;
    logic m_sm, m_sel, m_inc, m_dec;
    logic [1:0] m_ss;

    function automatic logic [8:0] mk(input logic sm, input logic sl, input logic [1:0] ss,
                                      input logic inc, input logic dec, input logic [2:0] fid);
        return {sm, sl, ss, inc, dec, fid};
    endfunction

    function automatic logic [8:0] model_exp();
        return mk(m_sm, m_sel, m_ss, m_inc, m_dec, 3'(m_field));
    endfunction

    task automatic model_reset();
        m_field = 0; m_pend = 0; m_idle = 0;
        m_sm = 0; m_sel = 0; m_ss = 0; m_inc = 1; m_dec = 1;
    endtask

    task automatic model_show_field();
        m_sm  = (m_field != 0);
        m_sel = (m_field >= 4);
        m_ss  = (m_field == 0) ? 2'd0 : 2'((m_field - 1) % 3);
    endtask

    task automatic model_press(input int op);
        m_idle = 0;
        case (op)
            OP_MODE: begin m_field = (m_field == 0) ? 1 : 0; m_pend = 0; end
            OP_NEXT: if (m_field != 0) begin m_field = (m_field == 6) ? 1 : m_field + 1; m_pend = 0; end
            OP_UP:   if (m_field != 0) m_pend = 1;
            OP_DOWN: if (m_field != 0) m_pend = 2;
            default: ;
        endcase
    endtask

    task automatic model_tick();
        logic shown_ok;
        shown_ok = m_sm && (m_sel == (m_field >= 4)) && (m_ss == 2'((m_field - 1) % 3));
        if (!m_inc || !m_dec) begin
            m_inc = 1; m_dec = 1;
            model_show_field();
        end else if (m_pend != 0 && m_field != 0 && shown_ok) begin
            if (m_pend == 1) m_inc = 0; else m_dec = 0;
            m_pend = 0;
        end else begin
            model_show_field();
        end
        if (m_field != 0) begin
            m_idle++;
            if (m_idle >= TO) begin m_field = 0; m_pend = 0; m_idle = 0; end
        end else begin
            m_idle = 0;
        end
    endtask

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] act;
        act = {set_mode, sel, set_select, inc_btn, dec_btn, field_id};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got sm=%0d sel=%0d ss=%0d inc=%0d dec=%0d fid=%0d, expected sm=%0d sel=%0d ss=%0d inc=%0d dec=%0d fid=%0d",
                     name, act[8], act[7], act[6:5], act[4], act[3], act[2:0],
                     exp[8], exp[7], exp[6:5], exp[4], exp[3], exp[2:0]);
        end
    endtask

    task automatic do_tick();
        @(negedge clk); upd_tick = 1'b1;
        @(negedge clk); upd_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // m bits: 0 mode, 1 next, 2 up, 3 down; held long enough to debounce, then released.
    task automatic press_btns(input logic [3:0] m);
        @(negedge clk);
        {down_btn_n, up_btn_n, next_btn_n, mode_btn_n} = ~m;
        repeat (DEB + 6) @(negedge clk);
        {down_btn_n, up_btn_n, next_btn_n, mode_btn_n} = 4'hF;
        repeat (DEB + 6) @(negedge clk);
    endtask

    task automatic apply_op(input int op);
        case (op)
            OP_TICK: begin do_tick(); model_tick(); end
            OP_MODE: begin press_btns(4'b0001); model_press(op); end
            OP_NEXT: begin press_btns(4'b0010); model_press(op); end
            OP_UP:   begin press_btns(4'b0100); model_press(op); end
            OP_DOWN: begin press_btns(4'b1000); model_press(op); end
            default: begin press_btns(4'b1100); model_press(op); end
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    typedef struct { int op; logic [8:0] exp; } vec_t;
    vec_t tbl[$];

    initial begin
        logic exp_inc;
        model_reset();
        do_reset();
        check("reset", mk(0, 0, 0, 1, 1, 0));

        for (int k = 0; k < 10; k++) begin
            apply_op(OP_TICK);
            check($sformatf("idle_tick%0d", k), mk(0, 0, 0, 1, 1, 0));
        end

        // Short bounces on mode must not register.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); mode_btn_n = 1'b0;
            repeat (3) @(negedge clk); mode_btn_n = 1'b1;
            repeat (3) @(negedge clk);
        end
        repeat (DEB + 6) @(negedge clk);
        check("bounce_ignored", mk(0, 0, 0, 1, 1, 0));
        apply_op(OP_MODE);
        check("mode_press", mk(0, 0, 0, 1, 1, 1));
        apply_op(OP_TICK);
        check("mode_tick", mk(1, 0, 0, 1, 1, 1));

        tbl.push_back('{OP_UP,   mk(1, 0, 0, 1, 1, 1)});
        tbl.push_back('{OP_TICK, mk(1, 0, 0, 0, 1, 1)});
        tbl.push_back('{OP_UP,   mk(1, 0, 0, 0, 1, 1)});
        tbl.push_back('{OP_TICK, mk(1, 0, 0, 1, 1, 1)});
        tbl.push_back('{OP_TICK, mk(1, 0, 0, 0, 1, 1)});
        tbl.push_back('{OP_TICK, mk(1, 0, 0, 1, 1, 1)});
        tbl.push_back('{OP_NEXT, mk(1, 0, 0, 1, 1, 2)});
        tbl.push_back('{OP_TICK, mk(1, 0, 1, 1, 1, 2)});
        tbl.push_back('{OP_DOWN, mk(1, 0, 1, 1, 1, 2)});
        tbl.push_back('{OP_TICK, mk(1, 0, 1, 1, 0, 2)});
        tbl.push_back('{OP_NEXT, mk(1, 0, 1, 1, 0, 3)});
        tbl.push_back('{OP_TICK, mk(1, 0, 2, 1, 1, 3)});
        tbl.push_back('{OP_NEXT, mk(1, 0, 2, 1, 1, 4)});
        tbl.push_back('{OP_TICK, mk(1, 1, 0, 1, 1, 4)});
        tbl.push_back('{OP_NEXT, mk(1, 1, 0, 1, 1, 5)});
        tbl.push_back('{OP_NEXT, mk(1, 1, 0, 1, 1, 6)});
        tbl.push_back('{OP_TICK, mk(1, 1, 2, 1, 1, 6)});
        tbl.push_back('{OP_NEXT, mk(1, 1, 2, 1, 1, 1)});
        tbl.push_back('{OP_TICK, mk(1, 0, 0, 1, 1, 1)});
        tbl.push_back('{OP_BOTH, mk(1, 0, 0, 1, 1, 1)});
        tbl.push_back('{OP_TICK, mk(1, 0, 0, 1, 1, 1)});
        tbl.push_back('{OP_NEXT, mk(1, 0, 0, 1, 1, 2)});
        tbl.push_back('{OP_UP,   mk(1, 0, 0, 1, 1, 2)});
        tbl.push_back('{OP_TICK, mk(1, 0, 1, 1, 1, 2)});
        tbl.push_back('{OP_TICK, mk(1, 0, 1, 0, 1, 2)});
        tbl.push_back('{OP_MODE, mk(1, 0, 1, 0, 1, 0)});
        tbl.push_back('{OP_TICK, mk(0, 0, 0, 1, 1, 0)});
        tbl.push_back('{OP_UP,   mk(0, 0, 0, 1, 1, 0)});
        tbl.push_back('{OP_TICK, mk(0, 0, 0, 1, 1, 0)});
        tbl.push_back('{OP_MODE, mk(0, 0, 0, 1, 1, 1)});
        tbl.push_back('{OP_TICK, mk(1, 0, 0, 1, 1, 1)});
        tbl.push_back('{OP_UP,   mk(1, 0, 0, 1, 1, 1)});
        tbl.push_back('{OP_NEXT, mk(1, 0, 0, 1, 1, 2)});
        tbl.push_back('{OP_TICK, mk(1, 0, 1, 1, 1, 2)});
        tbl.push_back('{OP_TICK, mk(1, 0, 1, 1, 1, 2)});
        tbl.push_back('{OP_UP,   mk(1, 0, 1, 1, 1, 2)});
        tbl.push_back('{OP_DOWN, mk(1, 0, 1, 1, 1, 2)});
        tbl.push_back('{OP_TICK, mk(1, 0, 1, 1, 0, 2)});
        tbl.push_back('{OP_TICK, mk(1, 0, 1, 1, 1, 2)});
        for (int i = 0; i < tbl.size(); i++) begin
            apply_op(tbl[i].op);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Three separate up presses, three ticks apart: one single-tick step each.
        for (int k = 0; k < 3; k++) begin
            apply_op(OP_UP);
            apply_op(OP_TICK);
            check($sformatf("up%0d_low", k), mk(1, 0, 1, 0, 1, 2));
            apply_op(OP_TICK);
            check($sformatf("up%0d_rel", k), mk(1, 0, 1, 1, 1, 2));
            apply_op(OP_TICK);
        end

        for (int k = 0; k < 120; k++) begin
            int r, op;
            r = $urandom_range(0, 9);
            op = (r < 5) ? OP_TICK : r - 4;
            apply_op(op);
            check($sformatf("rand%0d_op%0d", k, op), model_exp());
        end

        // Timeout from S_MIN: RUN after 30 quiet ticks, set_mode drops one tick later.
        do_reset();
        apply_op(OP_MODE);
        apply_op(OP_TICK);
        apply_op(OP_NEXT);
        check("to_start", mk(1, 0, 0, 1, 1, 2));
        for (int k = 1; k <= 31; k++) begin
            apply_op(OP_TICK);
            if (k < 30)       check($sformatf("to_tick%0d", k), mk(1, 0, 1, 1, 1, 2));
            else if (k == 30) check("to_tick30", mk(1, 0, 1, 1, 1, 0));
            else              check("to_tick31", mk(0, 0, 0, 1, 1, 0));
        end

        // Asynchronous reset while a decrement step is being driven.
        do_reset();
        apply_op(OP_MODE);
        apply_op(OP_TICK);
        apply_op(OP_DOWN);
        apply_op(OP_TICK);
        check("dec_active", mk(1, 0, 0, 1, 0, 1));
        @(negedge clk); #2 rst_n = 1'b0;
        #1 check("async_rst", mk(0, 0, 0, 1, 1, 0));
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        model_reset();

        // Hold up for ten ticks.
        apply_op(OP_MODE);
        apply_op(OP_TICK);
        @(negedge clk); up_btn_n = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            do_tick();
`ifdef AUTOREPEAT_EN
            exp_inc = (k % 2 == 1) ? 1'b0 : 1'b1;
`else
            exp_inc = (k == 1) ? 1'b0 : 1'b1;
`endif
            check($sformatf("hold_tick%0d", k), mk(1, 0, 0, exp_inc, 1, 1));
        end
        up_btn_n = 1'b1;
        repeat (DEB + 6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
